// File: rtl/sram_async_ctrl.sv
// rtl/sram_async_ctrl.sv - request-port controller for one external async SRAM
// Sequences setup/strobe/hold on registered pins, captures read data, and runs a zero-fill sweep.
module sram_async_ctrl #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   input  logic                  clear_start,
   output logic                  clear_done,
   output logic [ADDR_WIDTH-1:0] sram_address,
   inout  wire  [DATA_WIDTH-1:0] sram_data,
   output logic                  sram_chip_enable,
   output logic                  sram_write_enable,
   output logic                  sram_output_enable
);

   typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, CLR_NEXT} state_t;

   localparam logic [3:0]            PULSE_LOAD  = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0]            ACCESS_LOAD = 4'(WAIT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    clearing_q, clearing_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    clear_done_q, clear_done_d;
   logic                    ce_n_q, ce_n_d;
   logic                    we_n_q, we_n_d;
   logic                    oe_n_q, oe_n_d;
   logic                    drive_q, drive_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         clearing_q   <= 1'b0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         clear_done_q <= 1'b0;
         ce_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         drive_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         clearing_q   <= clearing_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         clear_done_q <= clear_done_d;
         ce_n_q       <= ce_n_d;
         we_n_q       <= we_n_d;
         oe_n_q       <= oe_n_d;
         drive_q      <= drive_d;
      end
   end

   // A clear sweep reuses the write sequence with data 0; clearing_q diverts W_HOLD to CLR_NEXT.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      clearing_d = clearing_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (clear_start) begin
               state_d    = W_SETUP;
               addr_d     = '0;
               wdata_d    = '0;
               clearing_d = 1'b1;
            end else if (req_valid) begin
               addr_d     = req_address;
               wdata_d    = req_wdata;
               clearing_d = 1'b0;
               if (req_write) begin
                  state_d = W_SETUP;
               end else begin
                  state_d = R_ACCESS;
                  cnt_d   = ACCESS_LOAD;
               end
            end
         end
         W_SETUP: begin
            state_d = W_PULSE;
            cnt_d   = PULSE_LOAD;
         end
         W_PULSE: begin
            if (cnt_q == 4'd0) state_d = W_HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         W_HOLD: state_d = clearing_q ? CLR_NEXT : IDLE;
         R_ACCESS: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         CLR_NEXT: begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (addr_q == LAST_ADDR) begin
               state_d    = IDLE;
               clearing_d = 1'b0;
            end else begin
               state_d = W_SETUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pin values are decoded from the next state so every SRAM pin comes straight from a flop.
   always_comb begin
      ce_n_d = 1'b1;
      we_n_d = 1'b1;
      oe_n_d = 1'b1;
      drive_d = 1'b0;
      case (state_d)
         W_SETUP, W_HOLD: begin
            ce_n_d  = 1'b0;
            drive_d = 1'b1;
         end
         W_PULSE: begin
            ce_n_d  = 1'b0;
            we_n_d  = 1'b0;
            drive_d = 1'b1;
         end
         R_ACCESS: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         default: ;
      endcase
      rsp_valid_d  = (state_q == R_ACCESS) && (cnt_q == 4'd0);
      rsp_rdata_d  = rsp_valid_d ? sram_data : rsp_rdata_q;
      clear_done_d = (state_q == CLR_NEXT) && (addr_q == LAST_ADDR);
   end

   assign req_ready          = (state_q == IDLE);
   assign rsp_valid          = rsp_valid_q;
   assign rsp_rdata          = rsp_rdata_q;
   assign clear_done         = clear_done_q;
   assign sram_address       = addr_q;
   assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign sram_chip_enable   = ce_n_q;
   assign sram_write_enable  = we_n_q;
   assign sram_output_enable = oe_n_q;

endmodule
